// File: rtl/pcm_stream_sync.sv
// pcm_stream_sync: synchronises a slow PCM strobe, detects the configured edge and
// buffers captured frames in a show-ahead FIFO. Define PCM_STREAM_SYNC_OVF_CNT_EN for the dropped-frame counter.
module pcm_stream_sync #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned EDGE_MODE   = 0
) (
   input  logic                             clk_fast,
   input  logic                             rst,
   input  logic                             pcm_valid_in,
   input  logic [NUM_CH*DATA_W-1:0]         pcm_data_in,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [NUM_CH*DATA_W-1:0]         out_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
   output logic                             ovf,
   output logic [15:0]                      ovf_count,
   input  logic                             ovf_clr
);
   localparam int unsigned FRAME_W = NUM_CH * DATA_W;
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned WARM_W  = $clog2(SYNC_STAGES + 2);
   localparam logic [WARM_W-1:0] WARM_END = WARM_W'(SYNC_STAGES + 1);
   localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic [WARM_W-1:0]      warm_q, warm_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic                   valid_q, valid_d;
   logic [FRAME_W-1:0]     head_q, head_d;
   logic                   ovf_q, ovf_d;
   logic [FRAME_W-1:0]     mem_q [FIFO_DEPTH];

   logic rise, fall, edge_det, warm_done, push, pop, full, wr_en, drop;

   // Edge detection, FIFO bookkeeping and next head frame
   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], pcm_valid_in};
      hist_d    = sync_q[SYNC_STAGES-1];
      rise      = sync_q[SYNC_STAGES-1] & ~hist_q;
      fall      = ~sync_q[SYNC_STAGES-1] & hist_q;
      if (EDGE_MODE == 0)      edge_det = rise;
      else if (EDGE_MODE == 1) edge_det = fall;
      else                     edge_det = rise | fall;

      warm_done = (warm_q == WARM_END);
      warm_d    = warm_done ? warm_q : warm_q + WARM_W'(1);

      push  = edge_det & warm_done;
      pop   = valid_q & out_ready;
      full  = (level_q == LVL_FULL);
      wr_en = push & (~full | pop);
      drop  = push & full & ~pop;

      wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      level_d = level_q;
      if (wr_en && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !wr_en) level_d = level_q - LVL_W'(1);

      valid_d = (level_d != '0);
      // The frame being written this cycle may become the new head
      if (!valid_d)                         head_d = '0;
      else if (wr_en && wr_ptr_q == rd_ptr_d) head_d = pcm_data_in;
      else                                  head_d = mem_q[rd_ptr_d];

      ovf_d = (ovf_clr ? 1'b0 : ovf_q) | drop;
   end

   always_ff @(posedge clk_fast) begin
      if (rst) begin
         sync_q   <= '0;
         hist_q   <= 1'b0;
         warm_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         hist_q   <= hist_d;
         warm_q   <= warm_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
         ovf_q    <= ovf_d;
      end
   end

   // Frame storage is not reset; out_valid masks stale contents
   always_ff @(posedge clk_fast) begin
      if (wr_en) mem_q[wr_ptr_q] <= pcm_data_in;
   end

`ifdef PCM_STREAM_SYNC_OVF_CNT_EN
   logic [15:0] cnt_q, cnt_d, cnt_base;

   // Clear takes effect before a same-cycle drop; saturates at all ones
   always_comb begin
      cnt_base = ovf_clr ? 16'd0 : cnt_q;
      cnt_d    = (drop && cnt_base != 16'hFFFF) ? cnt_base + 16'd1 : cnt_base;
   end

   always_ff @(posedge clk_fast) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign ovf_count = cnt_q;
`else
   assign ovf_count = 16'd0;
`endif

   assign out_valid  = valid_q;
   assign out_data   = head_q;
   assign fifo_level = level_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_pcm_stream_sync.sv
// Bench for pcm_stream_sync: a rising-edge and a both-edge instance checked every cycle
// against a queue-based reference model, plus directed checks of the key scenarios.
`timescale 1ns/1ps
module tb_pcm_stream_sync;
   localparam int unsigned S     = 2;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        valid_in [2];
   logic [31:0] data_in  [2];
   logic        ready    [2];
   logic        clr      [2];
   logic        o_valid  [2];
   logic [31:0] o_data   [2];
   logic [2:0]  o_level  [2];
   logic        o_ovf    [2];
   logic [15:0] o_cnt    [2];

   pcm_stream_sync #(.DATA_W(16), .NUM_CH(2), .SYNC_STAGES(S), .FIFO_DEPTH(DEPTH), .EDGE_MODE(0)) dut0 (
      .clk_fast(clk), .rst(rst), .pcm_valid_in(valid_in[0]), .pcm_data_in(data_in[0]),
      .out_valid(o_valid[0]), .out_ready(ready[0]), .out_data(o_data[0]), .fifo_level(o_level[0]),
      .ovf(o_ovf[0]), .ovf_count(o_cnt[0]), .ovf_clr(clr[0]));

   pcm_stream_sync #(.DATA_W(16), .NUM_CH(2), .SYNC_STAGES(S), .FIFO_DEPTH(DEPTH), .EDGE_MODE(2)) dut1 (
      .clk_fast(clk), .rst(rst), .pcm_valid_in(valid_in[1]), .pcm_data_in(data_in[1]),
      .out_valid(o_valid[1]), .out_ready(ready[1]), .out_data(o_data[1]), .fifo_level(o_level[1]),
      .ovf(o_ovf[1]), .ovf_count(o_cnt[1]), .ovf_clr(clr[1]));

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state: frame queue, input sample history (bit 0 newest), warm-up age
   logic [31:0] mq [2][$];
   logic [7:0]  hv [2];
   int unsigned since [2];
   bit          m_ovf [2];
   int unsigned m_cnt [2];

   function automatic logic [31:0] exp_cnt(input int u);
`ifdef PCM_STREAM_SYNC_OVF_CNT_EN
      return 32'(m_cnt[u]);
`else
      return 32'd0;
`endif
   endfunction

   task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s u%0d observed=0x%0h expected=0x%0h", tag, u, obs, exp);
      end
   endtask

   task automatic model_step(input int u);
      bit nw, od, ev, pop, full;
      if (rst) begin
         mq[u].delete();
         hv[u] = '0; since[u] = 0; m_ovf[u] = 0; m_cnt[u] = 0;
         return;
      end
      nw = hv[u][S-1];
      od = hv[u][S];
      ev = (u == 0) ? (nw && !od) : (nw != od);
      ev = ev && (since[u] >= S + 1);
      pop = (mq[u].size() != 0) && ready[u];
      if (clr[u]) begin m_ovf[u] = 0; m_cnt[u] = 0; end
      full = (mq[u].size() == DEPTH);
      if (pop) void'(mq[u].pop_front());
      if (ev) begin
         if (full && !pop) begin
            m_ovf[u] = 1;
            if (m_cnt[u] < 65535) m_cnt[u]++;
         end else mq[u].push_back(data_in[u]);
      end
      hv[u] = {hv[u][6:0], valid_in[u]};
      since[u]++;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      for (int u = 0; u < 2; u++) begin
         chk("m_valid", u, 32'(o_valid[u]), 32'(mq[u].size() != 0));
         chk("m_data",  u, o_data[u], (mq[u].size() != 0) ? mq[u][0] : 32'd0);
         chk("m_level", u, 32'(o_level[u]), 32'(mq[u].size()));
         chk("m_ovf",   u, 32'(o_ovf[u]), 32'(m_ovf[u]));
         chk("m_cnt",   u, 32'(o_cnt[u]), exp_cnt(u));
      end
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1; run(3); rst = 1'b0; run(S + 2);
   endtask

   // One rising edge on unit 0 with the given frame, then back low
   task automatic pulse0(input logic [31:0] d);
      data_in[0] = d; valid_in[0] = 1'b1; run(5);
      valid_in[0] = 1'b0; run(5);
   endtask

   initial begin
      int npop;
      int hold [2];
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         valid_in[u] = 1'b0; data_in[u] = '0; ready[u] = 1'b0; clr[u] = 1'b0;
      end

      // Reset values and latency
      run(3);
      chk("rst_valid", 0, 32'(o_valid[0]), 32'd0);
      chk("rst_data",  0, o_data[0], 32'd0);
      chk("rst_level", 0, 32'(o_level[0]), 32'd0);
      chk("rst_ovf",   0, 32'(o_ovf[0]), 32'd0);
      chk("rst_cnt",   0, 32'(o_cnt[0]), 32'd0);
      rst = 1'b0; run(S + 2);
      data_in[0] = 32'h1234ABCD; valid_in[0] = 1'b1;
      cyc(); chk("lat_e1", 0, 32'(o_valid[0]), 32'd0);
      cyc(); chk("lat_e2", 0, 32'(o_valid[0]), 32'd0);
      cyc(); chk("lat_e3", 0, 32'(o_valid[0]), 32'd1);
      chk("lat_data",  0, o_data[0], 32'h1234ABCD);
      chk("lat_level", 0, 32'(o_level[0]), 32'd1);
      valid_in[0] = 1'b0; run(5);

      // Valid held high through reset never captures
      data_in[0] = 32'h5555AAAA; valid_in[0] = 1'b1;
      rst = 1'b1; run(3); rst = 1'b0; run(12);
      chk("held_level", 0, 32'(o_level[0]), 32'd0);
      valid_in[0] = 1'b0; run(6); valid_in[0] = 1'b1; run(6);
      chk("held_recap", 0, 32'(o_level[0]), 32'd1);
      chk("held_data",  0, o_data[0], 32'h5555AAAA);
      valid_in[0] = 1'b0;

      // Overflow: six frames into a four-deep FIFO
      do_reset();
      for (int i = 1; i <= 6; i++) pulse0(32'(i));
      chk("ovf_level", 0, 32'(o_level[0]), 32'd4);
      chk("ovf_flag",  0, 32'(o_ovf[0]), 32'd1);
`ifdef PCM_STREAM_SYNC_OVF_CNT_EN
      chk("ovf_cnt", 0, 32'(o_cnt[0]), 32'd2);
`else
      chk("ovf_cnt", 0, 32'(o_cnt[0]), 32'd0);
`endif
      for (int i = 1; i <= 4; i++) begin
         chk("ovf_pop", 0, o_data[0], 32'(i));
         ready[0] = 1'b1; cyc(); ready[0] = 1'b0;
      end
      chk("ovf_empty", 0, 32'(o_level[0]), 32'd0);

      // Full FIFO with push and pop in the same cycle
      clr[0] = 1'b1; cyc(); clr[0] = 1'b0;
      for (int i = 11; i <= 14; i++) pulse0(32'(i));
      data_in[0] = 32'd15; valid_in[0] = 1'b1; run(S);
      ready[0] = 1'b1; cyc(); ready[0] = 1'b0;
      chk("pp_level", 0, 32'(o_level[0]), 32'd4);
      chk("pp_ovf",   0, 32'(o_ovf[0]), 32'd0);
      chk("pp_head",  0, o_data[0], 32'd12);
      valid_in[0] = 1'b0; run(5);
      for (int i = 12; i <= 15; i++) begin
         chk("pp_pop", 0, o_data[0], 32'(i));
         ready[0] = 1'b1; cyc(); ready[0] = 1'b0;
      end

      // Clear in the same cycle as an overflow drop
      for (int i = 21; i <= 26; i++) pulse0(32'(i));
      data_in[0] = 32'd27; valid_in[0] = 1'b1; run(S);
      clr[0] = 1'b1; cyc(); clr[0] = 1'b0;
      chk("clr_ovf", 0, 32'(o_ovf[0]), 32'd1);
`ifdef PCM_STREAM_SYNC_OVF_CNT_EN
      chk("clr_cnt", 0, 32'(o_cnt[0]), 32'd1);
`else
      chk("clr_cnt", 0, 32'(o_cnt[0]), 32'd0);
`endif
      valid_in[0] = 1'b0; run(5);

      // Both-edge mode: eight toggles, consumer always ready
      do_reset();
      ready[1] = 1'b1; npop = 0;
      for (int i = 0; i < 8; i++) begin
         valid_in[1] = ~valid_in[1]; data_in[1] = 32'(100 + i);
         repeat (50) begin
            cyc();
            if (o_valid[1]) begin
               chk("both_order", 1, o_data[1], 32'(100 + npop));
               npop++;
            end
         end
      end
      chk("both_count", 1, 32'(npop), 32'd8);
      chk("both_ovf",   1, 32'(o_ovf[1]), 32'd0);

      // Random traffic on both units with one mid-run reset
      hold[0] = 0; hold[1] = 0;
      for (int t = 0; t < 1500; t++) begin
         for (int u = 0; u < 2; u++) begin
            if (hold[u] == 0) begin
               valid_in[u] = ~valid_in[u];
               data_in[u]  = $urandom;
               hold[u]     = int'($urandom_range(4, 12));
            end else hold[u]--;
            clr[u] = ($urandom_range(0, 63) == 0);
         end
         ready[0] = ($urandom_range(0, 7) == 0);
         ready[1] = ($urandom_range(0, 3) != 0);
         rst = (t >= 700 && t < 702);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
